// File: rtl/iob2apb.sv
// IOb native bus to AMBA APB bridge: one outstanding transfer, IDLE -> SETUP -> ACCESS.
// Optional ACCESS-phase timeout with err_o pulse is enabled by defining IOB2APB_TIMEOUT_EN.
module iob2apb #(
    parameter int unsigned ADDR_W         = 21,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cke_i,
    input  logic                iob_avalid_i,
    input  logic [ADDR_W-1:0]   iob_addr_i,
    input  logic [DATA_W-1:0]   iob_wdata_i,
    input  logic [DATA_W/8-1:0] iob_wstrb_i,
    output logic                iob_ready_o,
    output logic                iob_rvalid_o,
    output logic [DATA_W-1:0]   iob_rdata_o,
    output logic                apb_sel_o,
    output logic                apb_enable_o,
    output logic                apb_write_o,
    output logic [ADDR_W-1:0]   apb_addr_o,
    output logic [DATA_W-1:0]   apb_wdata_o,
    output logic [DATA_W/8-1:0] apb_wstrb_o,
    input  logic [DATA_W-1:0]   apb_rdata_i,
    input  logic                apb_ready_i,
    output logic                err_o
);

    localparam int unsigned STRB_W = DATA_W / 8;

    if ((DATA_W % 8) != 0 || TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("iob2apb: DATA_W must be a multiple of 8 and TIMEOUT_CYCLES nonzero");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   accept_c;
    logic   done_c;
    logic   timeout_c;

    assign accept_c = iob_avalid_i & iob_ready_o;
    assign done_c   = (state == ACCESS) & apb_ready_i;

`ifdef IOB2APB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    // Cleared while in SETUP so it reads zero in the first ACCESS cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (cke_i) begin
            if (state == SETUP) begin
                cnt <= '0;
            end else if (state == ACCESS) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign timeout_c = (state == ACCESS) & ~apb_ready_i & (cnt == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (cke_i) begin
            err_o <= timeout_c;
        end
    end
`else
    assign timeout_c = 1'b0;
    assign err_o     = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else if (cke_i) begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (iob_avalid_i) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (done_c || timeout_c) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        iob_ready_o  = 1'b0;
        apb_sel_o    = 1'b0;
        apb_enable_o = 1'b0;
        case (state)
            IDLE:   iob_ready_o = 1'b1;
            SETUP:  apb_sel_o = 1'b1;
            ACCESS: begin
                apb_sel_o    = 1'b1;
                apb_enable_o = 1'b1;
            end
            default: ;
        endcase
    end

    // Request capture and read response
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            apb_addr_o   <= '0;
            apb_wdata_o  <= '0;
            apb_wstrb_o  <= '0;
            apb_write_o  <= 1'b0;
            iob_rvalid_o <= 1'b0;
            iob_rdata_o  <= '0;
        end else if (cke_i) begin
            iob_rvalid_o <= 1'b0;
            if (accept_c) begin
                apb_addr_o  <= iob_addr_i;
                apb_wdata_o <= iob_wdata_i;
                apb_wstrb_o <= STRB_W'(iob_wstrb_i);
                apb_write_o <= |iob_wstrb_i;
            end
            if (done_c && !apb_write_o) begin
                iob_rvalid_o <= 1'b1;
                iob_rdata_o  <= apb_rdata_i;
            end else if (timeout_c && !apb_write_o) begin
                iob_rvalid_o <= 1'b1;
                iob_rdata_o  <= '1;
            end
        end
    end

endmodule

// File: tb/tb_iob2apb.sv
// Directed self-checking bench for iob2apb: write, wait-state read, back-to-back,
// reset abort, clock enable freeze and (macro-dependent) ACCESS timeout.
module tb_iob2apb;

    logic        clk = 1'b0;
    logic        rst;
    logic        cke;
    logic        avalid;
    logic [20:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        sel;
    logic        enable;
    logic        write;
    logic [20:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready;
    logic        err;

    int total = 0;
    int bad   = 0;

    iob2apb #(.ADDR_W(21), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk), .rst_i(rst), .cke_i(cke),
        .iob_avalid_i(avalid), .iob_addr_i(addr), .iob_wdata_i(wdata), .iob_wstrb_i(wstrb),
        .iob_ready_o(ready), .iob_rvalid_o(rvalid), .iob_rdata_o(rdata),
        .apb_sel_o(sel), .apb_enable_o(enable), .apb_write_o(write),
        .apb_addr_o(paddr), .apb_wdata_o(pwdata), .apb_wstrb_o(pstrb),
        .apb_rdata_i(prdata), .apb_ready_i(pready), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++; if (ready !== 1'b1)   begin bad++; $display("FAIL reset_ready got=%0h exp=1", ready); end
        total++; if (sel !== 1'b0)     begin bad++; $display("FAIL reset_sel got=%0h exp=0", sel); end
        total++; if (enable !== 1'b0)  begin bad++; $display("FAIL reset_enable got=%0h exp=0", enable); end
        total++; if (write !== 1'b0)   begin bad++; $display("FAIL reset_write got=%0h exp=0", write); end
        total++; if (rvalid !== 1'b0)  begin bad++; $display("FAIL reset_rvalid got=%0h exp=0", rvalid); end
        total++; if (rdata !== 32'h0)  begin bad++; $display("FAIL reset_rdata got=%0h exp=0", rdata); end
        total++; if (paddr !== 21'h0)  begin bad++; $display("FAIL reset_addr got=%0h exp=0", paddr); end
        total++; if (pwdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%0h exp=0", pwdata); end
        total++; if (pstrb !== 4'h0)   begin bad++; $display("FAIL reset_wstrb got=%0h exp=0", pstrb); end
        total++; if (err !== 1'b0)     begin bad++; $display("FAIL reset_err got=%0h exp=0", err); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_write();
        pready = 1'b1;
        avalid = 1'b1; addr = 21'h10; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL wr_idle_ready got=%0h exp=1", ready); end
        step();
        avalid = 1'b0;
        total++; if ({sel, enable} !== 2'b10) begin bad++; $display("FAIL wr_setup_sel_en got=%0b exp=10", {sel, enable}); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL wr_setup_ready got=%0h exp=0", ready); end
        total++; if ({write, paddr, pwdata, pstrb} !== {1'b1, 21'h10, 32'hDEADBEEF, 4'hF})
            begin bad++; $display("FAIL wr_setup_bus got=%0h/%0h/%0h/%0h exp=1/10/deadbeef/f", write, paddr, pwdata, pstrb); end
        step();
        total++; if ({sel, enable} !== 2'b11) begin bad++; $display("FAIL wr_access_sel_en got=%0b exp=11", {sel, enable}); end
        total++; if ({write, paddr, pwdata, pstrb} !== {1'b1, 21'h10, 32'hDEADBEEF, 4'hF})
            begin bad++; $display("FAIL wr_access_bus got=%0h/%0h/%0h/%0h exp=1/10/deadbeef/f", write, paddr, pwdata, pstrb); end
        step();
        total++; if ({ready, sel, enable} !== 3'b100) begin bad++; $display("FAIL wr_done_state got=%0b exp=100", {ready, sel, enable}); end
        total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL wr_no_rvalid got=%0h exp=0", rvalid); end
        total++; if (err !== 1'b0)    begin bad++; $display("FAIL wr_err got=%0h exp=0", err); end
    endtask

    task automatic test_read_wait();
        int n;
        pready = 1'b0; prdata = 32'h12345678;
        avalid = 1'b1; addr = 21'h24; wstrb = 4'h0;
        step();
        avalid = 1'b0;
        total++; if (write !== 1'b0) begin bad++; $display("FAIL rd_write got=%0h exp=0", write); end
        step();
        n = 0;
        while (enable === 1'b1 && n < 20) begin
            pready = (n >= 4);
            step();
            n++;
        end
        pready = 1'b0;
        total++; if (n !== 5)        begin bad++; $display("FAIL rd_access_len got=%0d exp=5", n); end
        total++; if (rvalid !== 1'b1) begin bad++; $display("FAIL rd_rvalid got=%0h exp=1", rvalid); end
        total++; if (rdata !== 32'h12345678) begin bad++; $display("FAIL rd_rdata got=%0h exp=12345678", rdata); end
        total++; if (sel !== 1'b0)   begin bad++; $display("FAIL rd_sel_after got=%0h exp=0", sel); end
        prdata = 32'hA5A5A5A5;
        step();
        total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL rd_rvalid_one_cycle got=%0h exp=0", rvalid); end
        total++; if (rdata !== 32'h12345678) begin bad++; $display("FAIL rd_rdata_hold got=%0h exp=12345678", rdata); end
    endtask

    task automatic test_back_to_back();
        pready = 1'b1; prdata = 32'hCAFEF00D;
        avalid = 1'b1; addr = 21'h100; wdata = 32'h0; wstrb = 4'h0;
        step();
        total++; if ({write, paddr} !== {1'b0, 21'h100}) begin bad++; $display("FAIL b2b_rd_setup got=%0h/%0h exp=0/100", write, paddr); end
        addr = 21'h200; wdata = 32'h11223344; wstrb = 4'h3;
        step();
        total++; if ({enable, write, paddr} !== {1'b1, 1'b0, 21'h100})
            begin bad++; $display("FAIL b2b_rd_access got=%0h/%0h/%0h exp=1/0/100", enable, write, paddr); end
        step();
        total++; if ({rvalid, ready} !== 2'b11) begin bad++; $display("FAIL b2b_rvalid_ready got=%0b exp=11", {rvalid, ready}); end
        total++; if (rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL b2b_rdata got=%0h exp=cafef00d", rdata); end
        step();
        avalid = 1'b0;
        total++; if ({sel, enable, rvalid} !== 3'b100) begin bad++; $display("FAIL b2b_wr_setup got=%0b exp=100", {sel, enable, rvalid}); end
        total++; if ({write, paddr, pwdata, pstrb} !== {1'b1, 21'h200, 32'h11223344, 4'h3})
            begin bad++; $display("FAIL b2b_wr_bus got=%0h/%0h/%0h/%0h exp=1/200/11223344/3", write, paddr, pwdata, pstrb); end
        step();
        total++; if ({enable, write, paddr, pwdata} !== {1'b1, 1'b1, 21'h200, 32'h11223344})
            begin bad++; $display("FAIL b2b_wr_access got=%0h/%0h/%0h/%0h exp=1/1/200/11223344", enable, write, paddr, pwdata); end
        step();
        total++; if ({ready, rvalid} !== 2'b10) begin bad++; $display("FAIL b2b_wr_done got=%0b exp=10", {ready, rvalid}); end
    endtask

    task automatic test_reset_in_access();
        pready = 1'b0; prdata = 32'h0BADF00D;
        avalid = 1'b1; addr = 21'h30; wstrb = 4'h0;
        step();
        avalid = 1'b0;
        step();
        total++; if (enable !== 1'b1) begin bad++; $display("FAIL rst_in_access_pre got=%0h exp=1", enable); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if ({sel, enable, rvalid, ready, err} !== 5'b00010)
            begin bad++; $display("FAIL rst_abort got=%0b exp=00010", {sel, enable, rvalid, ready, err}); end
        total++; if (paddr !== 21'h0) begin bad++; $display("FAIL rst_abort_addr got=%0h exp=0", paddr); end
        step();
        total++; if ({sel, rvalid, err} !== 3'b000) begin bad++; $display("FAIL rst_abort_after got=%0b exp=000", {sel, rvalid, err}); end
    endtask

    task automatic test_cke();
        pready = 1'b1;
        cke = 1'b0; avalid = 1'b1; addr = 21'h44; wdata = 32'h55; wstrb = 4'h1;
        step();
        total++; if ({ready, sel} !== 2'b10) begin bad++; $display("FAIL cke_no_accept got=%0b exp=10", {ready, sel}); end
        cke = 1'b1;
        step();
        avalid = 1'b0; cke = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if ({sel, enable, write, paddr, pwdata} !== {1'b1, 1'b0, 1'b1, 21'h44, 32'h55})
                begin bad++; $display("FAIL cke_frozen_%0d got=%0h/%0h/%0h/%0h/%0h exp=1/0/1/44/55", i, sel, enable, write, paddr, pwdata); end
        end
        cke = 1'b1;
        step();
        total++; if ({sel, enable} !== 2'b11) begin bad++; $display("FAIL cke_resume_access got=%0b exp=11", {sel, enable}); end
        step();
        total++; if ({sel, ready} !== 2'b01) begin bad++; $display("FAIL cke_resume_done got=%0b exp=01", {sel, ready}); end
    endtask

    task automatic test_timeout();
        int n;
        pready = 1'b0; prdata = 32'h1;
        avalid = 1'b1; addr = 21'h50; wstrb = 4'h0;
        step();
        avalid = 1'b0;
        step();
`ifdef IOB2APB_TIMEOUT_EN
        // Counter reads 0..8 over the ACCESS cycles, expiring in the ninth.
        n = 0;
        while (enable === 1'b1 && n < 50) begin
            step();
            n++;
        end
        total++; if (n !== 9) begin bad++; $display("FAIL to_access_len got=%0d exp=9", n); end
        total++; if ({err, rvalid, sel} !== 3'b110) begin bad++; $display("FAIL to_pulse got=%0b exp=110", {err, rvalid, sel}); end
        total++; if (rdata !== 32'hFFFFFFFF) begin bad++; $display("FAIL to_rdata got=%0h exp=ffffffff", rdata); end
        step();
        total++; if ({err, rvalid} !== 2'b00) begin bad++; $display("FAIL to_one_cycle got=%0b exp=00", {err, rvalid}); end
`else
        n = 0;
        for (int i = 0; i < 120; i++) begin
            if (enable !== 1'b1 || err !== 1'b0) n++;
            step();
        end
        total++; if (n !== 0) begin bad++; $display("FAIL hold_access_bad_cycles got=%0d exp=0", n); end
        pready = 1'b1;
        step();
        pready = 1'b0;
        total++; if ({rvalid, err, rdata} !== {1'b1, 1'b0, 32'h1})
            begin bad++; $display("FAIL hold_release got=%0h/%0h/%0h exp=1/0/1", rvalid, err, rdata); end
`endif
    endtask

    initial begin
        rst = 1'b1; cke = 1'b1; avalid = 1'b0; addr = '0; wdata = '0; wstrb = '0;
        prdata = '0; pready = 1'b0;
        test_reset();
        test_write();
        test_read_wait();
        test_back_to_back();
        test_reset_in_access();
        test_cke();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
